// File: rtl/mips_pkg.sv
// Shared MIPS encodings for the front end.
// Opcode/funct constants and the default bubble word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_ctrl_if.sv
// Fetch <-> ID bus: fetched word in, redirect/stall out.
// master = fetch stage, slave = IF/ID control.
interface if_id_ctrl_if;

  logic [31:0] Instruction_if;
  logic [31:0] NextPC_if;
  logic        PC_IFWrite;
  logic        Z;
  logic        J;
  logic        JR;
  logic [31:0] JumpAddr;
  logic [31:0] JrAddr;
  logic [31:0] BranchAddr;

  modport master (
    output Instruction_if, NextPC_if,
    input  PC_IFWrite, Z, J, JR,
    input  JumpAddr, JrAddr, BranchAddr
  );

  modport slave (
    input  Instruction_if, NextPC_if,
    output PC_IFWrite, Z, J, JR,
    output JumpAddr, JrAddr, BranchAddr
  );

endinterface

// File: rtl/hazard_detect.sv
// ID-stage stall detection for load-use and
// branch/jr operands still in flight.
module hazard_detect (
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       rs_used,
  input  logic       rt_used,
  input  logic       is_br,
  input  logic       RegWrite_ex,
  input  logic       MemRead_ex,
  input  logic [4:0] WriteReg_ex,
  input  logic       MemRead_mem,
  input  logic [4:0] WriteReg_mem,
  output logic       Stall
);

  logic rs_live;
  logic rt_live;
  logic rs_hit;
  logic rt_hit;

  assign rs_live = rs_used && (rs != 5'd0);
  assign rt_live = rt_used && (rt != 5'd0);

  // Branches resolve in ID, so they also wait on ALU results in EX
  // and on loads that have only reached MEM.
  assign rs_hit =
      (MemRead_ex && WriteReg_ex == rs)
    || (is_br && RegWrite_ex && WriteReg_ex == rs)
    || (is_br && MemRead_mem && WriteReg_mem == rs);

  assign rt_hit =
      (MemRead_ex && WriteReg_ex == rt)
    || (is_br && RegWrite_ex && WriteReg_ex == rt)
    || (is_br && MemRead_mem && WriteReg_mem == rt);

  assign Stall = (rs_live && rs_hit) || (rt_live && rt_hit);

endmodule

// File: rtl/if_id_ctrl.sv
// IF/ID register, control-transfer decode, target
// arithmetic and saturating stall counter.
module if_id_ctrl
  import mips_pkg::*;
#(
  parameter int          CNT_W = 16,
  parameter logic [31:0] NOP   = mips_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              reset,
  if_id_ctrl_if.slave       fe,
  input  logic [31:0]       RsData_id,
  input  logic [31:0]       RtData_id,
  input  logic              RegWrite_ex,
  input  logic              MemRead_ex,
  input  logic [4:0]        WriteReg_ex,
  input  logic              MemRead_mem,
  input  logic [4:0]        WriteReg_mem,
  output logic [31:0]       Instruction_id,
  output logic [31:0]       NextPC_id,
  output logic              Valid_id,
  output logic              Stall,
  output logic [CNT_W-1:0]  StallCount
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        is_r;
  logic        is_beq;
  logic        is_bne;
  logic        is_j;
  logic        is_jr;
  logic        is_br;
  logic        rs_used;
  logic        rt_used;
  logic        go;
  logic        redirect;

  assign op  = Instruction_id[31:26];
  assign fn  = Instruction_id[5:0];
  assign rs  = Instruction_id[25:21];
  assign rt  = Instruction_id[20:16];
  assign imm = Instruction_id[15:0];

  assign is_r   = Valid_id && op == OP_RTYPE;
  assign is_beq = Valid_id && op == OP_BEQ;
  assign is_bne = Valid_id && op == OP_BNE;
  assign is_j   = Valid_id
               && (op == OP_J || op == OP_JAL);
  assign is_jr  = is_r && fn == FN_JR;
  assign is_br  = is_beq || is_bne || is_jr;

  assign rs_used = Valid_id
                && op != OP_J && op != OP_JAL;
  assign rt_used = is_r || is_beq || is_bne
                || (Valid_id && op == OP_SW);

  hazard_detect u_hazard (
    .rs           (rs),
    .rt           (rt),
    .rs_used      (rs_used),
    .rt_used      (rt_used),
    .is_br        (is_br),
    .RegWrite_ex  (RegWrite_ex),
    .MemRead_ex   (MemRead_ex),
    .WriteReg_ex  (WriteReg_ex),
    .MemRead_mem  (MemRead_mem),
    .WriteReg_mem (WriteReg_mem),
    .Stall        (Stall)
  );

  assign go = !Stall;

  assign fe.PC_IFWrite = !Stall;
  assign fe.Z  = go && (
      (is_beq && RsData_id == RtData_id)
    || (is_bne && RsData_id != RtData_id));
  assign fe.J  = go && is_j;
  assign fe.JR = go && is_jr;

  assign redirect = fe.Z || fe.J || fe.JR;

  assign fe.JumpAddr   = {NextPC_id[31:28],
                          Instruction_id[25:0], 2'b00};
  assign fe.BranchAddr = NextPC_id
                       + {{14{imm[15]}}, imm, 2'b00};
  assign fe.JrAddr     = RsData_id;

  // No delay slot: a taken redirect squashes the sequential fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      Instruction_id <= NOP;
      NextPC_id      <= 32'd0;
      Valid_id       <= 1'b0;
    end else if (!Stall) begin
      if (redirect) begin
        Instruction_id <= NOP;
        Valid_id       <= 1'b0;
      end else begin
        Instruction_id <= fe.Instruction_if;
        NextPC_id      <= fe.NextPC_if;
        Valid_id       <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if (Stall && StallCount != '1) begin
      StallCount <= StallCount
                  + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl: reset, hazards,
// redirects, flushes and counter saturation.
module tb_if_id_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   RsData_id, RtData_id;
  logic          RegWrite_ex, MemRead_ex, MemRead_mem;
  logic [4:0]    WriteReg_ex, WriteReg_mem;
  logic [31:0]   Instruction_id, NextPC_id;
  logic          Valid_id, Stall;
  logic [CW-1:0] StallCount;

  int errors = 0;
  int checks = 0;

  if_id_ctrl_if fe ();

  if_id_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .fe             (fe),
    .RsData_id      (RsData_id),
    .RtData_id      (RtData_id),
    .RegWrite_ex    (RegWrite_ex),
    .MemRead_ex     (MemRead_ex),
    .WriteReg_ex    (WriteReg_ex),
    .MemRead_mem    (MemRead_mem),
    .WriteReg_mem   (WriteReg_mem),
    .Instruction_id (Instruction_id),
    .NextPC_id      (NextPC_id),
    .Valid_id       (Valid_id),
    .Stall          (Stall),
    .StallCount     (StallCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [31:0] ins,
                       input logic [31:0] npc);
    fe.Instruction_if = ins;
    fe.NextPC_if      = npc;
  endtask

  initial begin
    reset = 1'b1;
    RsData_id = 0; RtData_id = 0;
    RegWrite_ex = 0; MemRead_ex = 0; MemRead_mem = 0;
    WriteReg_ex = 0; WriteReg_mem = 0;
    fetch(32'h2008_0005, 32'd4);

    tick(); tick(); #1;
    chk("rst_ins", Instruction_id, 32'h0);
    chk("rst_npc", NextPC_id, 32'h0);
    chk("rst_valid", {31'b0, Valid_id}, 32'd0);
    chk("rst_cnt", {28'b0, StallCount}, 32'd0);
    chk("rst_stall", {31'b0, Stall}, 32'd0);
    chk("rst_pcw", {31'b0, fe.PC_IFWrite}, 32'd1);
    chk("rst_zjjr", {29'b0, fe.Z, fe.J, fe.JR}, 32'd0);

    reset = 1'b0;
    tick(); #1;
    chk("first_ins", Instruction_id, 32'h2008_0005);
    chk("first_npc", NextPC_id, 32'd4);
    chk("first_valid", {31'b0, Valid_id}, 32'd1);

    // load-use on add $3,$1,$2
    fetch(32'h0022_1820, 32'd8);
    tick();
    fetch(32'h2009_0001, 32'd12);
    MemRead_ex = 1; WriteReg_ex = 5'd1;
    #1;
    chk("lu_stall", {31'b0, Stall}, 32'd1);
    chk("lu_pcw", {31'b0, fe.PC_IFWrite}, 32'd0);
    tick();
    chk("lu_hold", Instruction_id, 32'h0022_1820);
    chk("lu_cnt", {28'b0, StallCount}, 32'd1);
    MemRead_ex = 0; WriteReg_ex = 0;
    #1;
    chk("lu_clear", {31'b0, Stall}, 32'd0);
    tick(); #1;
    chk("lu_adv", Instruction_id, 32'h2009_0001);
    chk("lu_adv_npc", NextPC_id, 32'd12);

    // beq $1,$2,-1 taken
    fetch(32'h1022_FFFF, 32'h10);
    tick();
    fetch(32'h2008_0005, 32'h14);
    RsData_id = 7; RtData_id = 7;
    #1;
    chk("beq_z", {31'b0, fe.Z}, 32'd1);
    chk("beq_jjr", {30'b0, fe.J, fe.JR}, 32'd0);
    chk("beq_tgt", fe.BranchAddr, 32'h0000_000C);
    tick(); #1;
    chk("beq_flush", Instruction_id, 32'h0);
    chk("beq_fvalid", {31'b0, Valid_id}, 32'd0);

    // bne: not taken when equal, taken when different
    fetch(32'h1422_FFFF, 32'h20);
    tick();
    fetch(32'h2008_0005, 32'h24);
    #1;
    chk("bne_eq_z", {31'b0, fe.Z}, 32'd0);
    RtData_id = 8;
    #1;
    chk("bne_ne_z", {31'b0, fe.Z}, 32'd1);
    RtData_id = 7;
    tick(); #1;
    chk("bne_noflush", Instruction_id, 32'h2008_0005);
    chk("bne_valid", {31'b0, Valid_id}, 32'd1);

    // j 0x40
    fetch(32'h0800_0040, 32'h8000_0004);
    tick();
    fetch(32'h2008_0005, 32'h8000_0008);
    #1;
    chk("j_j", {31'b0, fe.J}, 32'd1);
    chk("j_zjr", {30'b0, fe.Z, fe.JR}, 32'd0);
    chk("j_tgt", fe.JumpAddr, 32'h8000_0100);
    tick(); #1;
    chk("j_flush", {31'b0, Valid_id}, 32'd0);

    // jr $31 behind an ALU write of $31
    fetch(32'h03E0_0008, 32'h40);
    tick();
    fetch(32'h2008_0005, 32'h44);
    RegWrite_ex = 1; WriteReg_ex = 5'd31;
    RsData_id = 32'h1234_5678;
    #1;
    chk("jr_stall", {31'b0, Stall}, 32'd1);
    chk("jr_jr0", {31'b0, fe.JR}, 32'd0);
    tick();
    chk("jr_cnt", {28'b0, StallCount}, 32'd2);
    chk("jr_hold", Instruction_id, 32'h03E0_0008);
    RegWrite_ex = 0; WriteReg_ex = 0;
    #1;
    chk("jr_jr1", {31'b0, fe.JR}, 32'd1);
    chk("jr_tgt", fe.JrAddr, 32'h1234_5678);
    tick(); #1;
    chk("jr_flush", Instruction_id, 32'h0);
    chk("jr_fvalid", {31'b0, Valid_id}, 32'd0);

    // beq on a load: EX stall then MEM stall
    fetch(32'h1022_0003, 32'h50);
    tick();
    fetch(32'h2008_0005, 32'h54);
    RsData_id = 1; RtData_id = 1;
    MemRead_ex = 1; WriteReg_ex = 5'd2;
    #1;
    chk("bl_ex", {31'b0, Stall}, 32'd1);
    chk("bl_ex_z", {31'b0, fe.Z}, 32'd0);
    tick();
    MemRead_ex = 0; WriteReg_ex = 0;
    MemRead_mem = 1; WriteReg_mem = 5'd2;
    #1;
    chk("bl_mem", {31'b0, Stall}, 32'd1);
    tick();
    MemRead_mem = 0; WriteReg_mem = 0;
    #1;
    chk("bl_cnt", {28'b0, StallCount}, 32'd4);
    chk("bl_z", {31'b0, fe.Z}, 32'd1);
    chk("bl_tgt", fe.BranchAddr, 32'h0000_005C);
    tick(); #1;
    chk("bl_flush", {31'b0, Valid_id}, 32'd0);

    // saturate: 2^CW+3 stall cycles
    fetch(32'h0022_1820, 32'h60);
    tick();
    MemRead_ex = 1; WriteReg_ex = 5'd2;
    for (int i = 0; i < (1 << CW) + 3; i++) tick();
    #1;
    chk("sat_cnt", {28'b0, StallCount}, 32'd15);
    chk("sat_stall", {31'b0, Stall}, 32'd1);

    // reset in the middle of a stall
    reset = 1'b1;
    tick(); #1;
    chk("mid_rst_ins", Instruction_id, 32'h0);
    chk("mid_rst_npc", NextPC_id, 32'h0);
    chk("mid_rst_cnt", {28'b0, StallCount}, 32'd0);
    chk("mid_rst_st", {31'b0, Stall}, 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
